// File: rtl/pipe_stage_fifo_pkg.sv
// Shared types and constants for the elastic pipeline-stage buffer.
// Payload-agnostic; the owning stage packs its fields into the data word.
package pipe_stage_fifo_pkg;

  localparam logic RST_ENABLE    = 1'b1;
  localparam int   DEPTH_MIN     = 2;
  localparam int   DEPTH_MAX     = 8;
  localparam int   DATA_W_MIN    = 1;
  localparam int   DATA_W_MAX    = 256;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/pipe_stage_fifo_ring.sv
// Wrap-aware ring pointer with clear and increment; 1-cycle update, no backpressure.
// Wraps DEPTH-1 -> 0 explicitly so non-power-of-two depths never leave the array.
module ring_ptr
  import pipe_stage_fifo_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_fifo.sv
// Elastic stage buffer, DEPTH words in order; pushed word visible next cycle, no bypass.
// in_ready is registered (full stalls upstream); rdy=0 freezes, flush discards and counts.
module pipe_stage_fifo
  import pipe_stage_fifo_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] NOP_DATA = '0,
  parameter int                KILL_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [DATA_W-1:0]            out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [KILL_W-1:0]            kill_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = ((KILL_W > CNT_W) ? KILL_W : CNT_W) + 1;

  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [KILL_W-1:0] KILL_MAX   = {KILL_W{1'b1}};
  localparam logic [SUM_W-1:0]  KILL_MAX_S = SUM_W'(KILL_MAX);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
    $error("pipe_stage_fifo: DEPTH must be in 2..8");
  end
  if (DATA_W < DATA_W_MIN || DATA_W > DATA_W_MAX) begin : g_bad_width
    $error("pipe_stage_fifo: DATA_W must be in 1..256");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  next_count;
  logic              in_ready_q;
  logic [KILL_W-1:0] kill_q;
  logic [KILL_W-1:0] kill_next;
  logic [SUM_W-1:0]  kill_sum;
  logic              flush_en;
  logic              push;
  logic              pop;

  // rdy gates the presented handshake signals, so push/pop inherit the freeze.
  assign in_ready  = in_ready_q & rdy;
  assign out_valid = (count_q != '0) & rdy;
  assign flush_en  = flush & rdy;
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  assign out_data  = out_valid ? mem[head] : NOP_DATA;
  assign count     = count_q;
  assign kill_cnt  = kill_q;

  always_comb begin
    next_count = count_q;
    case (decode_op(push, pop))
      OP_PUSH: next_count = count_q + 1'b1;
      OP_POP:  next_count = count_q - 1'b1;
      default: next_count = count_q;
    endcase
  end

  // Discarded entries include the word offered in the flush cycle if it would have been taken.
  always_comb begin
    kill_sum  = SUM_W'(kill_q) + SUM_W'(count_q) + SUM_W'(in_valid & in_ready);
    kill_next = (kill_sum > KILL_MAX_S) ? KILL_MAX : kill_sum[KILL_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      count_q    <= '0;
      in_ready_q <= 1'b1;
      kill_q     <= '0;
    end else if (rdy) begin
      if (flush) begin
        count_q    <= '0;
        in_ready_q <= 1'b1;
        kill_q     <= kill_next;
      end else begin
        count_q    <= next_count;
        in_ready_q <= (next_count < DEPTH_C);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail] <= in_data;
    end
  end

  ring_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_head (
    .clk (clk),
    .rst (rst),
    .clr (flush_en),
    .inc (pop),
    .ptr (head)
  );

  ring_ptr #(.DEPTH(DEPTH), .W(PTR_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .clr (flush_en),
    .inc (push),
    .ptr (tail)
  );

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Three buffers (DEPTH 3, 4, 2/KILL_W=2) share one stimulus; a queue-level model checks every cycle.
module tb_pipe_stage_fifo;

  logic       clk;
  logic       rst;
  logic       rdy;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       ir [3];
  logic       ov [3];
  logic [7:0] od [3];
  logic [3:0] cnt_g [3];
  logic [15:0] kill_g [3];

  logic [1:0]  c0;
  logic [2:0]  c1;
  logic [1:0]  c2;
  logic [15:0] k0;
  logic [15:0] k1;
  logic [1:0]  k2;

  int tests = 0;
  int fails = 0;

  pipe_stage_fifo #(.DATA_W(8), .DEPTH(3), .NOP_DATA(8'h00), .KILL_W(16)) u0 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
    .count(c0), .kill_cnt(k0)
  );
  pipe_stage_fifo #(.DATA_W(8), .DEPTH(4), .NOP_DATA(8'h5A), .KILL_W(16)) u1 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
    .count(c1), .kill_cnt(k1)
  );
  pipe_stage_fifo #(.DATA_W(8), .DEPTH(2), .NOP_DATA(8'hEE), .KILL_W(2)) u2 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready),
    .count(c2), .kill_cnt(k2)
  );

  assign cnt_g[0]  = {2'b00, c0};
  assign cnt_g[1]  = {1'b0, c1};
  assign cnt_g[2]  = {2'b00, c2};
  assign kill_g[0] = k0;
  assign kill_g[1] = k1;
  assign kill_g[2] = {14'd0, k2};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: each buffer is an ordered list plus an upstream-visible ready flag.
  int         m_depth [3] = '{3, 4, 2};
  int         m_kmax  [3] = '{65535, 65535, 3};
  logic [7:0] m_nop   [3] = '{8'h00, 8'h5A, 8'hEE};
  logic [7:0] m_dat [3][8];
  int         m_cnt [3];
  logic       m_ir  [3];
  int         m_kill [3];
  bit         model_ok = 0;

  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst) begin
          m_cnt[i]  = 0;
          m_ir[i]   = 1'b1;
          m_kill[i] = 0;
        end else if (rdy) begin
          if (flush) begin
            m_kill[i] = m_kill[i] + m_cnt[i] + ((in_valid && m_ir[i]) ? 1 : 0);
            if (m_kill[i] > m_kmax[i]) m_kill[i] = m_kmax[i];
            m_cnt[i] = 0;
            m_ir[i]  = 1'b1;
          end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (m_cnt[i] != 0) && out_ready;
            do_push = in_valid && m_ir[i];
            if (do_pop) begin
              for (int j = 0; j < 7; j++) m_dat[i][j] = m_dat[i][j+1];
              m_cnt[i]--;
            end
            if (do_push) begin
              m_dat[i][m_cnt[i]] = in_data;
              m_cnt[i]++;
            end
            m_ir[i] = (m_cnt[i] < m_depth[i]);
          end
        end
      end
      if (rst) model_ok = 1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        for (int i = 0; i < 3; i++) begin
          logic       e_ov;
          logic [7:0] e_od;
          logic       e_ir;
          e_ov = (m_cnt[i] != 0) && rdy;
          e_od = e_ov ? m_dat[i][0] : m_nop[i];
          e_ir = m_ir[i] && rdy;
          tests++;
          if (ov[i] !== e_ov || od[i] !== e_od || ir[i] !== e_ir ||
              cnt_g[i] !== 4'(m_cnt[i]) || kill_g[i] !== 16'(m_kill[i])) begin
            fails++;
            $display("FAIL model[%0d] t=%0t: got v=%b d=%h r=%b c=%0d k=%0d, want v=%b d=%h r=%b c=%0d k=%0d",
                     i, $time, ov[i], od[i], ir[i], cnt_g[i], kill_g[i],
                     e_ov, e_od, e_ir, m_cnt[i], m_kill[i]);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic o);
    in_valid  = v;
    in_data   = d;
    out_ready = o;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    tick(); tick();
    check("rst_in_ready",  32'(ir[0]), 1);
    check("rst_out_valid", 32'(ov[0]), 0);
    check("rst_out_data",  32'(od[0]), 32'h00);
    check("rst_nop_u2",    32'(od[2]), 32'hEE);
    check("rst_count",     32'(cnt_g[0]), 0);
    check("rst_kill",      32'(kill_g[0]), 0);
    rst = 1'b0;

    // basic transfer
    drive(1'b1, 8'hA5, 1'b1);
    tick();
    check("basic_valid", 32'(ov[0]), 1);
    check("basic_data",  32'(od[0]), 32'hA5);
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("basic_count0", 32'(cnt_g[0]), 0);
    check("basic_empty",  32'(ov[0]), 0);
    tick();
    check("empty_pop_nochange", 32'(cnt_g[0]), 0);

    // fill DEPTH=3 and drain in order
    drive(1'b1, 8'd1, 1'b0); tick();
    check("fill_c1", 32'(cnt_g[0]), 1);
    drive(1'b1, 8'd2, 1'b0); tick();
    check("fill_ir_after2", 32'(ir[0]), 1);
    drive(1'b1, 8'd3, 1'b0); tick();
    check("fill_full_ir", 32'(ir[0]), 0);
    check("fill_c3", 32'(cnt_g[0]), 3);
    drive(1'b1, 8'd4, 1'b0); tick();
    check("fill_held_c3", 32'(cnt_g[0]), 3);
    check("fill_u1_full_c4", 32'(cnt_g[1]), 4);
    out_ready = 1'b1;
    #1;
    check("drain_w1", 32'(od[0]), 1);
    check("drain_ir_pre", 32'(ir[0]), 0);
    tick();
    check("drain_ir_back", 32'(ir[0]), 1);
    check("drain_w2", 32'(od[0]), 2);
    check("drain_c2", 32'(cnt_g[0]), 2);
    tick();
    check("drain_w3", 32'(od[0]), 3);
    in_valid = 1'b0;
    tick();
    check("drain_w4", 32'(od[0]), 4);
    tick();
    check("drain_done", 32'(ov[0]), 0);
    repeat (3) tick();

    // streaming
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 8'(i + 1), 1'b1);
      tick();
      check("stream_d3_data", 32'(od[0]), 32'((i + 1) & 8'hFF));
      check("stream_d3_cnt",  32'(cnt_g[0]), 1);
      check("stream_d4_data", 32'(od[1]), 32'((i + 1) & 8'hFF));
      check("stream_d4_cnt",  32'(cnt_g[1]), 1);
    end
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("stream_drained", 32'(cnt_g[0]), 0);

    // flush with an offered word and a ready consumer
    drive(1'b1, 8'h11, 1'b0); tick();
    drive(1'b1, 8'h22, 1'b0); tick();
    flush = 1'b1;
    drive(1'b1, 8'h33, 1'b1);
    tick();
    flush = 1'b0;
    check("flush_count", 32'(cnt_g[0]), 0);
    check("flush_valid", 32'(ov[0]), 0);
    check("flush_nop",   32'(od[0]), 32'h00);
    check("flush_kill3", 32'(kill_g[0]), 3);
    check("flush_kill_u2_full", 32'(kill_g[2]), 2);
    check("flush_ir", 32'(ir[0]), 1);
    drive(1'b1, 8'h44, 1'b0); tick();
    drive(1'b1, 8'h55, 1'b0); tick();
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check("kill_sat_clamp", 32'(kill_g[2]), 3);
    check("kill_d3_5", 32'(kill_g[0]), 5);
    drive(1'b1, 8'h66, 1'b0); tick();
    flush = 1'b1; in_valid = 1'b0;
    tick();
    flush = 1'b0;
    check("kill_sat_hold", 32'(kill_g[2]), 3);
    check("kill_d3_6", 32'(kill_g[0]), 6);

    // freeze
    drive(1'b1, 8'h71, 1'b0); tick();
    drive(1'b1, 8'h72, 1'b0); tick();
    rdy = 1'b0;
    drive(1'b1, 8'h73, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("freeze_ir", 32'(ir[0]), 0);
      check("freeze_ov", 32'(ov[0]), 0);
      check("freeze_cnt", 32'(cnt_g[0]), 2);
    end
    rdy = 1'b1;
    #1;
    check("thaw_w71", 32'(od[0]), 32'h71);
    tick();
    check("thaw_w72", 32'(od[0]), 32'h72);
    check("thaw_cnt", 32'(cnt_g[0]), 2);
    in_valid = 1'b0;
    repeat (3) tick();

    // reset mid-operation, together with flush
    drive(1'b1, 8'h81, 1'b0); tick();
    drive(1'b1, 8'h82, 1'b0); tick();
    rst = 1'b1; flush = 1'b1;
    drive(1'b1, 8'h83, 1'b1);
    tick();
    rst = 1'b0; flush = 1'b0;
    check("rst_mid_cnt",  32'(cnt_g[0]), 0);
    check("rst_mid_kill", 32'(kill_g[0]), 0);
    check("rst_mid_kill_u2", 32'(kill_g[2]), 0);
    check("rst_mid_ir",   32'(ir[0]), 1);
    check("rst_mid_nop",  32'(od[0]), 32'h00);
    drive(1'b1, 8'h91, 1'b0);
    tick();
    check("resume_valid", 32'(ov[0]), 1);
    check("resume_data",  32'(od[0]), 32'h91);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised elastic pipeline-stage buffer for inter-stage boundaries (EX→MEM and similar): stores up to DEPTH payload words in order, exchanges them under valid/ready handshakes on both sides, and supports flush (mispredict kill) and the global `rdy` freeze. Its in_ready output is registered, so no combinational path from out_ready reaches in_ready. It replaces hard-wired stall-vector stage registers wherever a stage pair needs decoupling. The payload is opaque; the owning stage packs wd/wreg/wdata/aluop/addr/reg2/pc into it.

## Interface
- DATA_W, 32: payload width in bits; legal range 1..256.
- DEPTH, 2: entry count; legal range 2..8. DEPTH=1 is illegal and rejected at elaboration.
- NOP_DATA, 0: value driven on out_data whenever out_valid=0.
- KILL_W, 16: width of the flush-discard counter.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- rdy  in  1  global enable; 0 freezes all state.
- flush  in  1  discards all stored entries and this cycle's input.
- in_valid  in  1  upstream has a word.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  buffer accepts a word; registered.
- out_valid  out  1  head entry present.
- out_data  out  DATA_W  head payload, or NOP_DATA when out_valid=0.
- out_ready  in  1  downstream consumes the head word.
- count  out  $clog2(DEPTH+1)  current occupancy.
- kill_cnt  out  KILL_W  saturating total of entries discarded by flush.

## Operation
- Storage is a circular array of DEPTH entries with head and tail pointers. Each pointer wraps from DEPTH-1 to 0; non-power-of-two DEPTH is handled explicitly. Occupancy is tracked in `count`.
- push = in_valid & in_ready & rdy & !flush.
- pop = out_valid & out_ready & rdy & !flush.
- push only: entry written at tail, tail advances, count+1.
- pop only: head advances, count-1.
- push and pop together: both pointers advance, count unchanged. This case requires count ≥ 1.
- in_ready register: next value = (next_count < DEPTH). Deasserts the cycle after the buffer becomes full. Reasserts the cycle after the first pop from a full buffer.
- out_valid = (count ≠ 0) & rdy. out_data = out_valid ? mem[head] : NOP_DATA.
- flush (with rdy=1), on the next edge:
  - head, tail and count are cleared to 0.
  - in_ready is set to 1.
  - kill_cnt += count + (in_valid & in_ready), saturating at all-ones.
  - flush has priority over push and pop in the same cycle.
- rdy=0: pointers, count, memory, in_ready register and kill_cnt all hold. Combinationally, in_ready presents 0 and out_valid presents 0, so no handshake can complete.
- rst has priority over rdy and flush. It resets every state element, including kill_cnt.

## Timing
- Reset values:
  - in_ready=1 (registered value), out_valid=0, out_data=NOP_DATA, count=0, kill_cnt=0.
  - head and tail pointers are 0.
  - Memory contents are don't-care.
- Latency: a word pushed at edge N appears on out_valid/out_data in cycle N+1 when the buffer was empty. There is no combinational bypass from in_data to out_data.
- Throughput: one word per cycle sustained while out_ready stays 1, for any DEPTH ≥ 2.
- Full buffer: in_ready=0, so an offered word is not accepted and upstream must hold it. A pop in the same cycle does not enable a same-cycle push.
- Empty buffer with out_ready=1: no pop, and the state is unchanged.
- Flush in the same cycle as out_ready=1: the head word is not consumed and is counted in kill_cnt.
- Reset asserted mid-burst: all contents are lost with no kill_cnt accounting. Handshakes resume in the cycle after rst deasserts.
- kill_cnt saturation: an increment that would exceed 2^KILL_W-1 clamps to 2^KILL_W-1.

## Structure
- Shared `defines.v` header holds the reset, enable and NOP constants: RstEnable, WriteDisable, NopRegAddr, Exe_Nop_Op.
- Shared `defines.v` also holds per-stage payload width macros (e.g. ExMemPayloadW). Each stage's pack/unpack macros live beside these.
- A single sub-module, `ring_ptr`, is natural. It provides a wrap-aware pointer with increment enable and clear, and is instantiated twice (head, tail).
- count, kill_cnt and the in_ready register stay in the top-level module.

## Test plan
- Basic transfer: reset, then push 0xA5 with out_ready=1.
  - Required: out_valid=1 and out_data=0xA5 one cycle later.
  - Required: count returns to 0 after the pop.
- Fill and order (DEPTH=3, out_ready=0): push 1, 2, 3, 4.
  - Required: in_ready=0 after the third push; word 4 is held upstream; count=3.
  - Then raise out_ready: required output order is 1, 2, 3, 4, and in_ready reasserts one cycle after the first pop.
- Streaming: 100 words with in_valid=out_ready=1 continuously.
  - Required: one word per cycle and count stays at 1.
  - Exercise pointer wrap with DEPTH=3 and DEPTH=4.
- Flush: hold 2 entries and assert flush with in_valid=1, in_ready=1 and out_ready=1.
  - Required: count=0 and out_data=NOP_DATA next cycle, kill_cnt=3, and no word is seen downstream.
  - Also: with KILL_W=2 and kill_cnt already 3, a further flush keeps kill_cnt at 3.
- Freeze: hold 2 entries, then drop rdy for 5 cycles with in_valid=out_ready=1.
  - Required: in_ready=0 and out_valid=0 throughout, count stays 2, and the original order resumes when rdy returns.
- Reset mid-operation: assert rst with 2 entries held and flush=1 in the same cycle.
  - Required: count=0, kill_cnt=0, in_ready=1 and out_data=NOP_DATA on the following cycle.
